imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes RV32I words into instruction memory and
// releases the core on a good frame. Define LOADER_CHECKSUM_EN for the trailing XOR checksum.
module imem_loader #(
  parameter int          DEPTH = 64,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [7:0]  r_count;
  logic [7:0]  r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;
  logic        r_rx_ready;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;
  logic        r_cpu_rst_n;
  logic        r_done;
  logic        r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic w_accept;
  logic w_is_sync;
  logic w_bad_count;
  logic w_last_word;

  assign w_accept    = rx_valid && r_rx_ready;
  assign w_is_sync   = (rx_data == SYNC);
  assign w_bad_count = (rx_data == 8'd0) || (rx_data > DEPTH_B);
  assign w_last_word = (r_word_idx == (r_count - 8'd1));

  // NOTE: every register here, including the partial-word buffer, sits on the async
  // reset so a mid-frame reset discards all progress at once; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_rx_ready  <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_rx_ready <= 1'b1;
      r_we       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_sync) r_state <= S_COUNT;
        end
        S_COUNT: begin
          if (w_accept) begin
            if (w_bad_count) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_count    <= rx_data;
              r_word_idx <= '0;
              r_byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
              r_csum     <= '0;
`endif
              r_state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ rx_data;
`endif
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_we       <= 1'b1;
              r_wdata    <= {rx_data, r_word};
              r_waddr    <= {22'd0, r_word_idx, 2'b00};
              r_word_idx <= r_word_idx + 8'd1;
              if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                r_state <= S_CHECK;
`else
                r_state <= S_DONE;
`endif
              end
            end else begin
              r_word[{r_byte_idx, 3'b000} +: 8] <= rx_data;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) begin
            if (rx_data == r_csum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          // Entering DONE from DATA raises done here, one cycle after the final write.
          r_done      <= 1'b1;
          r_cpu_rst_n <= 1'b1;
          if (w_accept && w_is_sync) begin
            r_state     <= S_COUNT;
            r_done      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
          end
        end
        S_ERR: begin
          if (w_accept && w_is_sync) begin
            r_state <= S_COUNT;
            r_error <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_ready  = r_rx_ready;
  assign we        = r_we;
  assign waddr     = r_waddr;
  assign wdata     = r_wdata;
  assign cpu_rst_n = r_cpu_rst_n;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames checked
// against a frame-level reference model. Honours LOADER_CHECKSUM_EN like the design.
module tb_imem_loader;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int total = 0;
  int bad = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.DEPTH(DEPTH), .SYNC(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (we) begin
      wr_addr_q.push_back(waddr);
      wr_data_q.push_back(wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int wait_cnt;
    tick(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    wait_cnt = 0;
    while (!rx_ready && wait_cnt < 50) begin
      tick(1);
      wait_cnt++;
    end
    if (wait_cnt >= 50) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$], input int max_gap);
    foreach (bs[i]) send_byte(bs[i], $urandom_range(0, max_gap));
  endtask

  // Reference frame builder: SYNC, count, words LSB first, optional XOR checksum.
  task automatic make_frame(input logic [31:0] words[$], input logic corrupt,
                            output logic [7:0] bs[$]);
    logic [7:0] ck;
    ck = 8'h00;
    bs = {};
    bs.push_back(8'hA5);
    bs.push_back(8'(words.size()));
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        bs.push_back(words[i][8*k +: 8]);
        ck = ck ^ words[i][8*k +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (corrupt) ck = ck ^ 8'(($urandom_range(1, 255)));
    bs.push_back(ck);
`else
    if (corrupt) ck = 8'h00;
`endif
  endtask

  task automatic check_writes(input string tag, input logic [31:0] exp[$]);
    check({tag, "_nwr"}, 32'(wr_data_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wr_data_q.size(); i++) begin
      check({tag, "_waddr"}, wr_addr_q[i], 32'(i * 4));
      check({tag, "_wdata"}, wr_data_q[i], exp[i]);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_status(input string tag, input logic exp_done, input logic exp_err);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_waddr"}, waddr, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check_status(tag, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  bs[$];
    logic [31:0] ws[$];
    logic [31:0] none[$];
    none = {};

    // Reset state
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(1);
    check("reset_rx_ready_after", 32'(rx_ready), 32'd1);

    // Two-word frame, byte per cycle, with end-of-frame timing
    bs = '{8'hA5, 8'h02, 8'h93, 8'h82, 8'h41, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_bytes(bs, 0);
    check("t1_we_last", 32'(we), 32'd1);
    check("t1_waddr_last", waddr, 32'd4);
    check("t1_wdata_last", wdata, 32'hDEADBEEF);
    check("t1_done_early", 32'(done), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h72, 0);
    check_status("t1_ck", 1'b1, 1'b0);
`else
    tick(1);
    check("t1_we_drop", 32'(we), 32'd0);
    check_status("t1", 1'b1, 1'b0);
`endif
    check("t1_wdata_hold", wdata, 32'hDEADBEEF);
    ws = '{32'h00418293, 32'hDEADBEEF};
    check_writes("t1", ws);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum, then recovery frame
    bs = '{8'hA5, 8'h02, 8'h93, 8'h82, 8'h41, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h73};
    send_bytes(bs, 0);
    check_status("t2_bad", 1'b0, 1'b1);
    check_writes("t2_bad", ws);
    bs = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_bytes(bs, 0);
    check_status("t2_fix", 1'b1, 1'b0);
    ws = '{32'h00000013};
    check_writes("t2_fix", ws);
`endif

    // Illegal counts: 0 and DEPTH+1
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    check_status("t3_zero", 1'b0, 1'b1);
    send_byte(8'hA5, 0);
    check("t3_err_clr", 32'(error), 32'd0);
    send_byte(8'(DEPTH + 1), 0);
    check_status("t3_big", 1'b0, 1'b1);
    tick(2);
    check_writes("t3", none);

    // Leading junk ignored
    bs = '{8'h11, 8'h22, 8'hA5, 8'h01, 8'h33, 8'h22, 8'h11, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    bs.push_back(8'h00);
`endif
    send_bytes(bs, 0);
    tick(2);
    check_status("t4", 1'b1, 1'b0);
    ws = '{32'h00112233};
    check_writes("t4", ws);

    // rx_valid every other cycle, three words
    ws = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C};
    make_frame(ws, 1'b0, bs);
    foreach (bs[i]) send_byte(bs[i], 1);
    tick(2);
    check_status("t5", 1'b1, 1'b0);
    check_writes("t5", ws);

    // Reset mid-frame after byte 2 of word 1
    bs = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB};
    send_bytes(bs, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    ws = '{32'h04030201};
    check_writes("t6_pre", ws);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    ws = '{32'hCAFEF00D};
    make_frame(ws, 1'b0, bs);
    send_bytes(bs, 0);
    tick(2);
    check_status("t6_post", 1'b1, 1'b0);
    check_writes("t6_post", ws);

    // Randomized frames against the frame-level model
    for (int it = 0; it < 30; it++) begin
      int kind;
      int n;
      logic [7:0] b;
      logic exp_err;
      logic [31:0] exp_w[$];
      bs = {};
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        bs.push_back(b);
      end
      send_bytes(bs, 1);
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 255);
        bs = '{8'hA5, 8'(n)};
        send_bytes(bs, 2);
        exp_err = 1'b1;
        exp_w = {};
      end else begin
        n = (it == 7) ? DEPTH : $urandom_range(1, 8);
        ws = {};
        for (int i = 0; i < n; i++) ws.push_back($urandom);
`ifdef LOADER_CHECKSUM_EN
        exp_err = (kind == 1);
`else
        exp_err = 1'b0;
`endif
        make_frame(ws, kind == 1, bs);
        send_bytes(bs, 2);
        exp_w = ws;
      end
      tick(3);
      check_status($sformatf("rnd%0d", it), !exp_err, exp_err);
      check_writes($sformatf("rnd%0d", it), exp_w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
